// File: rtl/zbb_seq.sv
// zbb_seq: sequential RISC-V Zbb bit-manipulation unit.
// Single-step ops finish on the accept edge; CLZ/CTZ/CPOP scan STEP bits per cycle.
module zbb_seq #(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] din_rs1,
    input  logic [XLEN-1:0] din_rs2,
    input  logic [11:0]     immI,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] dout_rd,
    output logic            illegal
);
    localparam int SHW  = $clog2(XLEN);
    localparam int NCYC = XLEN / STEP;
    localparam int CW   = $clog2(XLEN + 1);
    localparam int YW   = $clog2(NCYC + 1);

    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [YW-1:0] CYC_ONE  = {{(YW-1){1'b0}}, 1'b1};
    localparam logic [YW-1:0] CYC_LAST = YW'(NCYC - 1);

    localparam logic [4:0] OP_ANDN  = 5'd0;
    localparam logic [4:0] OP_ORN   = 5'd1;
    localparam logic [4:0] OP_XNOR  = 5'd2;
    localparam logic [4:0] OP_CLZ   = 5'd3;
    localparam logic [4:0] OP_CTZ   = 5'd4;
    localparam logic [4:0] OP_CPOP  = 5'd5;
    localparam logic [4:0] OP_MAX   = 5'd6;
    localparam logic [4:0] OP_MAXU  = 5'd7;
    localparam logic [4:0] OP_MIN   = 5'd8;
    localparam logic [4:0] OP_MINU  = 5'd9;
    localparam logic [4:0] OP_SEXTB = 5'd10;
    localparam logic [4:0] OP_SEXTH = 5'd11;
    localparam logic [4:0] OP_ZEXTH = 5'd12;
    localparam logic [4:0] OP_ROL   = 5'd13;
    localparam logic [4:0] OP_ROR   = 5'd14;
    localparam logic [4:0] OP_RORI  = 5'd15;
    localparam logic [4:0] OP_ORCB  = 5'd16;
    localparam logic [4:0] OP_REV8  = 5'd17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_r;
    logic [4:0]        op_r;
    logic [XLEN-1:0]   shreg_r;
    logic [CW-1:0]     cnt_r;
    logic [YW-1:0]     cyc_r;
    logic              found_r;

    logic [XLEN-1:0]   alu_s;
    logic              illegal_s;
    logic              is_count_s;
    logic [CW-1:0]     cnt_nxt_s;
    logic              found_nxt_s;
    logic [XLEN-1:0]   shreg_nxt_s;
    logic              imm_unused_s;

    function automatic logic [XLEN-1:0] rotl(input logic [XLEN-1:0] a, input logic [SHW-1:0] sh);
        logic [2*XLEN-1:0] d;
        d = {a, a} << sh;
        return d[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] rotr(input logic [XLEN-1:0] a, input logic [SHW-1:0] sh);
        logic [2*XLEN-1:0] d;
        d = {a, a} >> sh;
        return d[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] orc_b(input logic [XLEN-1:0] a);
        logic [XLEN-1:0] r;
        r = {XLEN{1'b0}};
        for (int b = 0; b < XLEN / 8; b++) begin
            r[b*8 +: 8] = (|a[b*8 +: 8]) ? 8'hFF : 8'h00;
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] rev8(input logic [XLEN-1:0] a);
        logic [XLEN-1:0] r;
        r = {XLEN{1'b0}};
        for (int b = 0; b < XLEN / 8; b++) begin
            r[b*8 +: 8] = a[(XLEN/8-1-b)*8 +: 8];
        end
        return r;
    endfunction

    // Result of every single-step op; counting and illegal encodings yield zero.
    function automatic logic [XLEN-1:0] alu(input logic [4:0] o, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b, input logic [SHW-1:0] im);
        logic [XLEN-1:0] r;
        case (o)
            OP_ANDN:  r = a & ~b;
            OP_ORN:   r = a | ~b;
            OP_XNOR:  r = ~(a ^ b);
            OP_MAX:   r = ($signed(a) < $signed(b)) ? b : a;
            OP_MAXU:  r = (a < b) ? b : a;
            OP_MIN:   r = ($signed(b) < $signed(a)) ? b : a;
            OP_MINU:  r = (b < a) ? b : a;
            OP_SEXTB: r = {{(XLEN-8){a[7]}}, a[7:0]};
            OP_SEXTH: r = {{(XLEN-16){a[15]}}, a[15:0]};
            OP_ZEXTH: r = {{(XLEN-16){1'b0}}, a[15:0]};
            OP_ROL:   r = rotl(a, b[SHW-1:0]);
            OP_ROR:   r = rotr(a, b[SHW-1:0]);
            OP_RORI:  r = rotr(a, im);
            OP_ORCB:  r = orc_b(a);
            OP_REV8:  r = rev8(a);
            default:  r = {XLEN{1'b0}};
        endcase
        return r;
    endfunction

    // Handshake and single-step result decode from the live request.
    always_comb begin
        in_ready     = (state_r == IDLE);
        alu_s        = alu(op, din_rs1, din_rs2, immI[SHW-1:0]);
        illegal_s    = (op > OP_REV8);
        is_count_s   = (op == OP_CLZ) || (op == OP_CTZ) || (op == OP_CPOP);
        imm_unused_s = ^immI[11:SHW];
    end

    // One scan step: CLZ consumes from the MSB end, CTZ/CPOP from the LSB end.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        found_nxt_s = found_r;
        if (op_r == OP_CLZ) begin
            shreg_nxt_s = shreg_r << STEP;
        end else begin
            shreg_nxt_s = shreg_r >> STEP;
        end
        for (int i = 0; i < STEP; i++) begin
            if (op_r == OP_CPOP) begin
                if (shreg_r[i]) begin
                    cnt_nxt_s = cnt_nxt_s + CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_nxt_s;
                end
            end else if (op_r == OP_CLZ) begin
                if (found_nxt_s || shreg_r[XLEN-1-i]) begin
                    found_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_nxt_s + CNT_ONE;
                end
            end else begin
                if (found_nxt_s || shreg_r[i]) begin
                    found_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_nxt_s + CNT_ONE;
                end
            end
        end
    end

    // Control FSM with registered result and handshake outputs; kill outranks everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            op_r      <= 5'd0;
            shreg_r   <= {XLEN{1'b0}};
            cnt_r     <= {CW{1'b0}};
            cyc_r     <= {YW{1'b0}};
            found_r   <= 1'b0;
            out_valid <= 1'b0;
            dout_rd   <= {XLEN{1'b0}};
            illegal   <= 1'b0;
        end else if (kill) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            cyc_r     <= {YW{1'b0}};
            found_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r <= op;
                        if (is_count_s) begin
                            state_r <= COUNT;
                            shreg_r <= din_rs1;
                            cnt_r   <= {CW{1'b0}};
                            cyc_r   <= {YW{1'b0}};
                            found_r <= 1'b0;
                        end else begin
                            state_r   <= DONE;
                            dout_rd   <= alu_s;
                            illegal   <= illegal_s;
                            out_valid <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                COUNT: begin
                    cnt_r   <= cnt_nxt_s;
                    found_r <= found_nxt_s;
                    shreg_r <= shreg_nxt_s;
                    cyc_r   <= cyc_r + CYC_ONE;
                    if (cyc_r == CYC_LAST) begin
                        state_r   <= DONE;
                        dout_rd   <= {{(XLEN-CW){1'b0}}, cnt_nxt_s};
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        state_r <= COUNT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zbb_seq.sv
// Self-checking bench for zbb_seq (XLEN=32, STEP=4): directed table, corner
// sequences, and randomized ops against a plain-arithmetic reference model.
module tb_zbb_seq;
    localparam int XLEN = 32;
    localparam int STEP = 4;
    localparam int NCYC = XLEN / STEP;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      op = 5'd0;
    logic [XLEN-1:0] rs1 = 32'h0;
    logic [XLEN-1:0] rs2 = 32'h0;
    logic [11:0]     imm = 12'h0;
    logic            kill = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] dout_rd;
    logic            illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    zbb_seq #(.XLEN(XLEN), .STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .din_rs1(rs1), .din_rs2(rs2), .immI(imm), .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready), .dout_rd(dout_rd),
        .illegal(illegal)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [11:0] im;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {illegal, result} straight from the instruction definitions.
    function automatic logic [32:0] model(input logic [4:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [11:0] im);
        logic [31:0] r;
        int n;
        int s;
        r = 32'h0;
        n = 0;
        case (o)
            5'd0: r = a & ~b;
            5'd1: r = a | ~b;
            5'd2: r = ~(a ^ b);
            5'd3: begin
                for (int i = 31; i >= 0; i--) begin
                    if (a[i]) break;
                    n++;
                end
                r = n;
            end
            5'd4: begin
                for (int i = 0; i < 32; i++) begin
                    if (a[i]) break;
                    n++;
                end
                r = n;
            end
            5'd5: r = $countones(a);
            5'd6: r = ($signed(a) >= $signed(b)) ? a : b;
            5'd7: r = (a >= b) ? a : b;
            5'd8: r = ($signed(a) <= $signed(b)) ? a : b;
            5'd9: r = (a <= b) ? a : b;
            5'd10: r = 32'($signed(a[7:0]));
            5'd11: r = 32'($signed(a[15:0]));
            5'd12: r = a & 32'h0000FFFF;
            5'd13: begin
                s = int'(b % 32'd32);
                r = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
            end
            5'd14: begin
                s = int'(b % 32'd32);
                r = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
            end
            5'd15: begin
                s = int'(im % 12'd32);
                r = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
            end
            5'd16: begin
                for (int k = 0; k < 4; k++) begin
                    if (a[8*k +: 8] != 8'h00) r[8*k +: 8] = 8'hFF;
                end
            end
            5'd17: r = {a[7:0], a[15:8], a[23:16], a[31:24]};
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, r};
    endfunction

    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [11:0] im, input logic [32:0] expv, input int hold,
                          input string name);
        int lat;
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk({name, " ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; rs1 = a; rs2 = b; imm = im;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 5'($urandom); rs1 = $urandom; rs2 = $urandom; imm = 12'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, 64'(lat), (o >= 5'd3 && o <= 5'd5) ? 64'(NCYC + 1) : 64'd1);
        chk({name, " dout_rd"}, 64'(dout_rd), 64'(expv[31:0]));
        chk({name, " illegal"}, 64'(illegal), 64'(expv[32]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        if (hold > 0) chk({name, " held"}, 64'({out_valid, illegal, dout_rd}), 64'({1'b1, expv}));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " drained"}, 64'({out_valid, in_ready}), 64'd1);
    endtask

    initial begin
        logic [4:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [11:0] ri;
        logic        seen;

        tbl[0]  = '{5'd3,  32'h00010000, 32'h0,        12'h0,  32'd15,       1'b0};
        tbl[1]  = '{5'd3,  32'h00000000, 32'h0,        12'h0,  32'd32,       1'b0};
        tbl[2]  = '{5'd4,  32'h80000000, 32'h0,        12'h0,  32'd31,       1'b0};
        tbl[3]  = '{5'd5,  32'hFFFFFFFF, 32'h0,        12'h0,  32'd32,       1'b0};
        tbl[4]  = '{5'd5,  32'h00000000, 32'h0,        12'h0,  32'd0,        1'b0};
        tbl[5]  = '{5'd13, 32'h80000001, 32'h00000021, 12'h0,  32'h00000003, 1'b0};
        tbl[6]  = '{5'd15, 32'h0000000F, 32'h0000001F, 12'h4,  32'hF0000000, 1'b0};
        tbl[7]  = '{5'd17, 32'h11223344, 32'h0,        12'h0,  32'h44332211, 1'b0};
        tbl[8]  = '{5'd16, 32'h00010080, 32'h0,        12'h0,  32'h00FF00FF, 1'b0};
        tbl[9]  = '{5'd8,  32'hFFFFFFFF, 32'h00000001, 12'h0,  32'hFFFFFFFF, 1'b0};
        tbl[10] = '{5'd9,  32'hFFFFFFFF, 32'h00000001, 12'h0,  32'h00000001, 1'b0};
        tbl[11] = '{5'd20, 32'h12345678, 32'h9ABCDEF0, 12'hFFF, 32'h0,       1'b1};
        tbl[12] = '{5'd14, 32'hDEADBEEF, 32'h00000020, 12'h0,  32'hDEADBEEF, 1'b0};
        tbl[13] = '{5'd14, 32'h00000001, 32'h00000001, 12'h0,  32'h80000000, 1'b0};
        tbl[14] = '{5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 12'h0,  32'h00F000F0, 1'b0};
        tbl[15] = '{5'd1,  32'h0000000F, 32'hFFFFFF00, 12'h0,  32'h000000FF, 1'b0};
        tbl[16] = '{5'd2,  32'h12345678, 32'h12345678, 12'h0,  32'hFFFFFFFF, 1'b0};
        tbl[17] = '{5'd6,  32'h80000000, 32'h7FFFFFFF, 12'h0,  32'h7FFFFFFF, 1'b0};
        tbl[18] = '{5'd7,  32'h80000000, 32'h7FFFFFFF, 12'h0,  32'h80000000, 1'b0};
        tbl[19] = '{5'd10, 32'h12345680, 32'h0,        12'h0,  32'hFFFFFF80, 1'b0};
        tbl[20] = '{5'd11, 32'h00008000, 32'h0,        12'h0,  32'hFFFF8000, 1'b0};
        tbl[21] = '{5'd12, 32'hFFFF8000, 32'h0,        12'h0,  32'h00008000, 1'b0};
        tbl[22] = '{5'd4,  32'h00000000, 32'h0,        12'h0,  32'd32,       1'b0};
        tbl[23] = '{5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'h0,  32'h0,        1'b1};

        #12;
        chk("reset outputs", 64'({out_valid, in_ready, illegal, dout_rd}), 64'({3'b010, 32'h0}));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].im, {tbl[i].ill, tbl[i].exp}, 0, "table");
        end

        // Illegal op stalled in DONE while a new request is offered.
        in_valid = 1'b1; op = 5'd20; rs1 = 32'hA5A5A5A5; rs2 = 32'h1;
        @(posedge clk); #1;
        op = 5'd0;
        for (int i = 0; i < 3; i++) begin
            chk("stall hold", 64'({out_valid, in_ready, illegal, dout_rd}), 64'({3'b101, 32'h0}));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall release", 64'({out_valid, in_ready}), 64'd1);

        // Kill during the third COUNT cycle of a CLZ.
        in_valid = 1'b1; op = 5'd3; rs1 = 32'h00010000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill count", 64'({out_valid, in_ready}), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("kill no result", 64'(seen), 64'd0);

        // Kill beats a simultaneous accept.
        in_valid = 1'b1; op = 5'd0; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        chk("kill vs accept", 64'({out_valid, in_ready}), 64'd1);

        // Kill in DONE together with out_ready.
        in_valid = 1'b1; op = 5'd17; rs1 = 32'h01020304;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre-kill done", 64'({out_valid, dout_rd}), 64'({1'b1, 32'h04030201}));
        kill = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; out_ready = 1'b0;
        chk("kill in done", 64'({out_valid, in_ready}), 64'd1);

        run_op(5'd3, 32'h00010000, 32'h0, 12'h0, model(5'd3, 32'h00010000, 32'h0, 12'h0), 1, "post-kill clz");

        // Asynchronous reset while a result is pending.
        in_valid = 1'b1; op = 5'd1; rs1 = 32'h0; rs2 = 32'h0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset", 64'({out_valid, in_ready, illegal, dout_rd}), 64'({3'b010, 32'h0}));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("reset no result", 64'(seen), 64'd0);

        for (int n = 0; n < 150; n++) begin
            ro = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: ra = $urandom;
                1: ra = $urandom >> $urandom_range(0, 31);
                2: ra = $urandom << $urandom_range(0, 31);
                default: ra = 32'h1 << $urandom_range(0, 31);
            endcase
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            ri = 12'($urandom);
            run_op(ro, ra, rb, ri, model(ro, ra, rb, ri), $urandom_range(0, 2), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zbb_seq.md
ZBB_SEQ -- requirements
Module: zbb_seq

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values 32 and 64.
REQ-002 Parameter STEP, default 4: bits examined per cycle by counting ops; legal values 1, 2, 4, 8; STEP divides XLEN.
REQ-003 Localparam SHW = log2(XLEN): shift-amount width.
REQ-004 Ports, in order:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- op  in  5  operation select (REQ-007).
- din_rs1  in  XLEN  operand A.
- din_rs2  in  XLEN  operand B.
- immI  in  12  I-type immediate.
- kill  in  1  synchronous abort of any in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- dout_rd  out  XLEN  result.
- illegal  out  1  qualifies dout_rd: op was not a defined encoding.

Function
REQ-005 FSM states: IDLE, COUNT, DONE. in_ready = (state == IDLE), combinational.
REQ-006 Accept = in_valid && in_ready; on accept, op, operands and immI[SHW-1:0] are captured; inputs are ignored until the next accept.
REQ-007 op encoding:
- 0 ANDN, 1 ORN, 2 XNOR, 3 CLZ, 4 CTZ, 5 CPOP, 6 MAX, 7 MAXU, 8 MIN
- 9 MINU, 10 SEXT.B, 11 SEXT.H, 12 ZEXT.H, 13 ROL, 14 ROR, 15 RORI, 16 ORC.B, 17 REV8
- 18-31 illegal.
REQ-008 Non-counting ops (all except 3-5) and illegal ops: IDLE -> DONE on accept; the result is registered into dout_rd the same edge; out_valid rises the cycle after accept.
REQ-009 Counting ops (3-5): IDLE -> COUNT on accept. Each COUNT cycle processes STEP bits: CLZ from MSB down, CTZ from LSB up, CPOP in any order. After exactly XLEN/STEP COUNT cycles: -> DONE. Latency is fixed (no early exit): out_valid rises XLEN/STEP+1 cycles after accept.
REQ-010 CLZ/CTZ stop incrementing at the first 1 seen; a zero operand yields XLEN. CPOP yields the number of 1s. All count results are zero-extended to XLEN.
REQ-011 MAX/MIN compare signed; MAXU/MINU compare unsigned; equal operands return din_rs1.
REQ-012 ROL/ROR rotate by din_rs2[SHW-1:0]. RORI rotates right by the captured immI[SHW-1:0], never by din_rs2. Rotate by 0 returns din_rs1.
REQ-013 ORC.B: each result byte is 0xFF if the corresponding din_rs1 byte is nonzero, else 0x00. REV8 reverses byte order across XLEN.
REQ-014 SEXT.B/SEXT.H sign-extend bit 7/15 to XLEN; ZEXT.H zero-extends bits 15:0.
REQ-015 Illegal op: dout_rd = 0, illegal = 1, delivered through DONE like any other result. illegal = 0 for defined ops.
REQ-016 In DONE: out_valid = 1; dout_rd and illegal hold stable while out_ready = 0. DONE -> IDLE on out_ready. No accept occurs in the DONE cycle, so back-to-back throughput is at most one op per two cycles.
REQ-017 kill = 1: next state is IDLE from any state; out_valid = 0 next cycle; the partial count is discarded. kill beats a simultaneous accept or out_ready; the request is not taken and the result is not delivered.
REQ-018 out_valid is driven only from state; it never depends combinationally on inputs.

Reset
REQ-019 While rst_n = 0: state = IDLE, out_valid = 0, dout_rd = 0, illegal = 0, internal counters = 0, in_ready = 1.
REQ-020 Reset asserted mid-COUNT or in DONE discards the operation; after release the unit is in IDLE with no result pending.

Verification (XLEN=32, STEP=4)
REQ-021 CLZ, rs1 = 0x00010000 -> dout_rd = 15, out_valid 9 cycles after accept; CLZ, rs1 = 0 -> 32.
REQ-022 CTZ, rs1 = 0x80000000 -> 31; CPOP, rs1 = 0xFFFFFFFF -> 32; CPOP, rs1 = 0x00000000 -> 0.
REQ-023 ROL, rs1 = 0x80000001, rs2 = 0x21 -> 0x00000003; RORI, imm = 4, rs2 = 0x1F, rs1 = 0x0000000F -> 0xF0000000.
REQ-024 REV8 0x11223344 -> 0x44332211; ORC.B 0x00010080 -> 0x00FF00FF; MIN 0xFFFFFFFF vs 1 -> 0xFFFFFFFF; MINU -> 1.
REQ-025 op = 20 -> illegal = 1, dout_rd = 0, one cycle after accept; out_ready held 0 for 3 cycles -> outputs stable, in_ready = 0 throughout.
REQ-026 kill at COUNT cycle 3 of a CLZ -> IDLE next cycle, no out_valid; rst_n pulsed low in DONE -> out_valid = 0 immediately (asynchronous reset), in_ready = 1.
